// File: rtl/rat_io_pkg.sv
// Shared I/O map for the RAT MCU peripherals: colour/brightness/fade port IDs,
// the RGB triple type, the colour palette and the duty arithmetic helpers.
package rat_io_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam int unsigned NUM_COLORS     = 10;
  localparam logic [7:0]  COLOR_FIRST_ID = 8'h95;
  localparam logic [7:0]  BRIGHT_ID      = 8'h9F;
  localparam logic [7:0]  FADE_ID        = 8'hA0;

  // Order: RED, BLUE, LIBLUE, LIGREEN, LIRED, YELLOW, PURPLE, GREEN, WHITE, BLACK
  localparam rgb_t PALETTE [NUM_COLORS] = '{
    '{r: 8'hFF, g: 8'h00, b: 8'h00},
    '{r: 8'h00, g: 8'h00, b: 8'hFF},
    '{r: 8'h40, g: 8'hC0, b: 8'hFF},
    '{r: 8'h80, g: 8'hFF, b: 8'h80},
    '{r: 8'hFF, g: 8'h60, b: 8'h60},
    '{r: 8'hFF, g: 8'hFF, b: 8'h00},
    '{r: 8'h80, g: 8'h00, b: 8'hFF},
    '{r: 8'h00, g: 8'hFF, b: 8'h00},
    '{r: 8'hFF, g: 8'hFF, b: 8'hFF},
    '{r: 8'h00, g: 8'h00, b: 8'h00}
  };

  // (pal * (bright + 1)) >> 8: bright = FF is transparent, bright = 00 gives 0.
  function automatic logic [7:0] scale_duty(input logic [7:0] pal, input logic [7:0] bright);
    logic [15:0] prod;
    prod = 16'(pal) * (16'(bright) + 16'd1);
    return prod[15:8];
  endfunction

  // Move cur toward tgt by at most step; step = 0 jumps straight to tgt.
  function automatic logic [7:0] fade_step(input logic [7:0] cur, input logic [7:0] tgt,
                                           input logic [7:0] step);
    logic [7:0] diff;
    diff = (cur < tgt) ? (tgt - cur) : (cur - tgt);
    if (step == 8'd0 || diff <= step) return tgt;
    return (cur < tgt) ? (cur + step) : (cur - step);
  endfunction

endpackage

// File: rtl/rgb_pwm_ctrl_if.sv
// MCU output-port bus: one-cycle strobed write of OUT_PORT to PORT_ID.
interface rgb_pwm_ctrl_if;
  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;

  modport master (output PORT_ID, output OUT_PORT, output IO_STRB);
  modport slave  (input  PORT_ID, input  OUT_PORT, input  IO_STRB);
endinterface

// File: rtl/pwm_fade_chan.sv
// One LED channel: holds the current duty, fades it toward the target at each
// period boundary and compares it against the shared PWM counter.
module pwm_fade_chan
  import rat_io_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       period_tick,
  input  logic [7:0] pwm_cnt,
  input  logic [7:0] target,
  input  logic [7:0] step,
  output logic       pwm_out,
  output logic       fading
);

  logic [7:0] duty_q, duty_d;
  logic       pwm_out_q, pwm_out_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    duty_d = duty_q;
    if (period_tick) duty_d = fade_step(duty_q, target, step);
    // Compare against the next duty so the boundary cycle already uses the new value.
    pwm_out_d = (pwm_cnt < duty_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q    <= 8'd0;
      pwm_out_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      duty_q    <= duty_d;
      pwm_out_q <= pwm_out_d;
    end
  end

  assign pwm_out = pwm_out_q;
  assign fading  = (duty_q != target);

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// RGB LED PWM controller on the RAT MCU port bus: palette colour select,
// global brightness, per-period fading, and a shared prescaled 8-bit PWM counter.
module rgb_pwm_ctrl
  import rat_io_pkg::*;
#(
  parameter int unsigned PRESCALE = 196,
  parameter logic [7:0]  FIRST_ID = COLOR_FIRST_ID
) (
  input  logic          CLK,
  input  logic          RESET_N,
  rgb_pwm_ctrl_if.slave bus,
  output logic          RED,
  output logic          GREEN,
  output logic          BLUE,
  output logic          PERIOD_TICK,
  output logic          FADING
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          tick_q, tick_d;
  rgb_t          target_q, target_d;
  logic [7:0]    bright_q, bright_d;
  logic [7:0]    step_q, step_d;
  logic [7:0]    sel;
  logic          step_last;
  rgb_t          eff;
  logic          fade_r, fade_g, fade_b;

  always_comb begin
    step_last = (presc_q == PW'(PRESCALE - 1));
    presc_d   = step_last ? '0 : presc_q + 1'b1;
    cnt_d     = step_last ? cnt_q + 8'd1 : cnt_q;
    tick_d    = step_last && (cnt_q == 8'hFF);

    target_d  = target_q;
    bright_d  = bright_q;
    step_d    = step_q;
    sel       = bus.PORT_ID - FIRST_ID;
    if (bus.IO_STRB) begin
      if (bus.PORT_ID == BRIGHT_ID)    bright_d = bus.OUT_PORT;
      else if (bus.PORT_ID == FADE_ID) step_d   = bus.OUT_PORT;
      else if (sel < 8'(NUM_COLORS))
        target_d = (bus.OUT_PORT != 8'd0) ? PALETTE[sel[3:0]] : '0;
    end

    eff.r = scale_duty(target_q.r, bright_q);
    eff.g = scale_duty(target_q.g, bright_q);
    eff.b = scale_duty(target_q.b, bright_q);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      presc_q  <= '0;
      cnt_q    <= 8'd0;
      tick_q   <= 1'b0;
      target_q <= '0;
      bright_q <= 8'hFF;
      step_q   <= 8'd0;
    end else begin
      presc_q  <= presc_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      target_q <= target_d;
      bright_q <= bright_d;
      step_q   <= step_d;
    end
  end

  // Channels see the registered target/STEP/BRIGHT, so a write on the tick cycle lands next period.
  pwm_fade_chan u_chan_r (
    .clk(CLK), .rst_n(RESET_N), .period_tick(tick_q), .pwm_cnt(cnt_q),
    .target(eff.r), .step(step_q), .pwm_out(RED), .fading(fade_r)
  );

  pwm_fade_chan u_chan_g (
    .clk(CLK), .rst_n(RESET_N), .period_tick(tick_q), .pwm_cnt(cnt_q),
    .target(eff.g), .step(step_q), .pwm_out(GREEN), .fading(fade_g)
  );

  pwm_fade_chan u_chan_b (
    .clk(CLK), .rst_n(RESET_N), .period_tick(tick_q), .pwm_cnt(cnt_q),
    .target(eff.b), .step(step_q), .pwm_out(BLUE), .fading(fade_b)
  );

  assign PERIOD_TICK = tick_q;
  assign FADING      = fade_r | fade_g | fade_b;

endmodule
